float_copro_mc: RTL and testbench

//  Multi-cycle, parametrised floating-point coprocessor for the LM32 copro port.

---
 rtl/float_copro_mc.sv | 242 ++++++++++++++++++++++++
 tb/tb_float_copro_mc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/float_copro_mc.sv
// Multi-cycle floating-point coprocessor (add/sub/mul/div) for the LM32 copro port.
// Truncating arithmetic, denormals flushed to zero, iterative restoring mantissa divider.
module float_copro_mc #(
    parameter int Nm      = 23,
    parameter int Ne      = 8,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           copro_valid,
    input  logic [10:0]    copro_opcode,
    input  logic [Nm+Ne:0] copro_op0,
    input  logic [Nm+Ne:0] copro_op1,
    output logic           copro_complete,
    output logic [Nm+Ne:0] copro_result,
    output logic           copro_busy,
    output logic [3:0]     copro_flags
);
    localparam int W       = Nm + Ne + 1;
    localparam int MW      = Nm + 1;
    localparam int AW      = 2 * Nm + 4;
    localparam int EW      = Ne + 8;
    localparam int DIV_LAT = Nm + 4;
    localparam int CW      = $clog2(DIV_LAT + ADD_LAT + MUL_LAT + 1);

    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (Ne - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << Ne) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [W-1:0] NAN_W = {1'b0, {Ne{1'b1}}, 1'b1, {(Nm-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t          state_q, state_n;
    logic            capture, finish, abort, release_c;
    logic [CW-1:0]   cnt_q, lat_c;
    logic [W-1:0]    a_q, b_q;
    logic [1:0]      op_q;
    logic [MW:0]     rem_q, quot_q;

    logic            sa, sb, sx, sy, a_ge_b, a_zero, b_zero, nan_in, sticky, s_res;
    logic [Ne-1:0]   ea, eb, ex, ey, d;
    logic [MW-1:0]   ma, mb, mx, my;
    logic [AW-1:0]   mx_e, my_e, ys, sum, norm;
    logic [2*MW-1:0] prod;
    int unsigned     p;
    logic signed [EW-1:0] e_res;
    logic [Nm-1:0]   m_res;
    logic [W+1:0]    packed_c;
    logic [W-1:0]    res_c;
    logic [3:0]      flags_c;
    logic            unused_ok;

    assign unused_ok = ^{copro_opcode[10:2], prod, norm};

    function automatic logic [MW-1:0] hidden_mant(input logic [W-1:0] x);
        hidden_mant = (x[W-2:Nm] == '0) ? '0 : {1'b1, x[Nm-1:0]};
    endfunction

    function automatic int unsigned msb_pos(input logic [AW-1:0] v);
        msb_pos = 0;
        for (int i = 0; i < AW; i++) begin
            if (v[i]) msb_pos = i;
        end
    endfunction

    // Saturate the normalised exponent: returns {overflow, underflow, word}
    function automatic logic [W+1:0] pack_sat(input logic s, input logic signed [EW-1:0] e,
                                              input logic [Nm-1:0] m);
        if (e >= EMAX)        pack_sat = {2'b10, s, {Ne{1'b1}}, {Nm{1'b0}}};
        else if (e <= E_ZERO) pack_sat = {2'b01, s, {(Ne+Nm){1'b0}}};
        else                  pack_sat = {2'b00, s, e[Ne-1:0], m};
    endfunction

    always_comb begin
        case (copro_opcode[1:0])
            OP_DIV:  lat_c = CW'(DIV_LAT - 1);
            OP_MUL:  lat_c = CW'(MUL_LAT - 1);
            default: lat_c = CW'(ADD_LAT - 1);
        endcase
    end

    always_comb begin
        sa     = a_q[W-1];
        sb     = b_q[W-1] ^ (op_q == OP_SUB);
        ea     = a_q[W-2:Nm];
        eb     = b_q[W-2:Nm];
        ma     = hidden_mant(a_q);
        mb     = hidden_mant(b_q);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        nan_in = (&ea) | (&eb);

        // Adder works on x = larger magnitude; bits shifted out of y become a borrow on subtract
        a_ge_b = {ea, ma} >= {eb, mb};
        sx     = a_ge_b ? sa : sb;
        sy     = a_ge_b ? sb : sa;
        ex     = a_ge_b ? ea : eb;
        ey     = a_ge_b ? eb : ea;
        mx     = a_ge_b ? ma : mb;
        my     = a_ge_b ? mb : ma;
        d      = ex - ey;
        mx_e   = {1'b0, mx, {(Nm+2){1'b0}}};
        my_e   = {1'b0, my, {(Nm+2){1'b0}}};
        ys     = my_e >> d;
        sticky = (ys << d) != my_e;
        sum    = (sx == sy) ? mx_e + ys : mx_e - ys - AW'(sticky);
        p      = msb_pos(sum);
        norm   = sum << (AW - 1 - p);

        prod   = (2*MW)'(ma) * (2*MW)'(mb);

        s_res  = sa ^ sb;
        e_res  = E_ZERO;
        m_res  = '0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                s_res = sx;
                e_res = $signed(EW'(ex)) + $signed(EW'(p)) - EW'(AW - 2);
                m_res = norm[AW-2 -: Nm];
            end
            OP_MUL: begin
                e_res = $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS + $signed(EW'(prod[2*MW-1]));
                m_res = prod[2*MW-1] ? prod[2*MW-2 -: Nm] : prod[2*MW-3 -: Nm];
            end
            default: begin
                e_res = $signed(EW'(ea)) - $signed(EW'(eb)) + BIAS - $signed(EW'(!quot_q[MW]));
                m_res = quot_q[MW] ? quot_q[Nm:1] : quot_q[Nm-1:0];
            end
        endcase

        packed_c = pack_sat(s_res, e_res, m_res);
        res_c    = packed_c[W-1:0];
        flags_c  = {2'b00, packed_c[W+1:W]};

        // Special operands, lowest priority first
        if ((op_q == OP_ADD || op_q == OP_SUB) && sum == '0) begin
            res_c   = '0;
            flags_c = '0;
        end
        if (op_q == OP_MUL && (a_zero || b_zero)) begin
            res_c   = {s_res, {(W-1){1'b0}}};
            flags_c = '0;
        end
        if (op_q == OP_DIV) begin
            if (a_zero && b_zero) begin
                res_c   = NAN_W;
                flags_c = 4'b1000;
            end else if (b_zero) begin
                res_c   = {s_res, {Ne{1'b1}}, {Nm{1'b0}}};
                flags_c = 4'b0100;
            end else if (a_zero) begin
                res_c   = {s_res, {(W-1){1'b0}}};
                flags_c = '0;
            end
        end
        if (nan_in) begin
            res_c   = NAN_W;
            flags_c = 4'b1000;
        end
    end

    always_comb begin
        state_n   = state_q;
        capture   = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        release_c = 1'b0;
        case (state_q)
            S_IDLE: if (copro_valid) begin
                capture = 1'b1;
                state_n = S_EXEC;
            end
            S_EXEC: if (!copro_valid) begin
                abort   = 1'b1;
                state_n = S_IDLE;
            end else if (cnt_q == '0) begin
                finish  = 1'b1;
                state_n = S_DONE;
            end
            S_DONE: if (!copro_valid) begin
                release_c = 1'b1;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            copro_complete <= 1'b0;
            copro_busy     <= 1'b0;
            copro_result   <= '0;
            copro_flags    <= '0;
        end else begin
            state_q <= state_n;
            if (capture) begin
                cnt_q       <= lat_c;
                copro_busy  <= 1'b1;
                copro_flags <= '0;
            end else if (state_q == S_EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (finish) begin
                copro_busy     <= 1'b0;
                copro_complete <= 1'b1;
                copro_result   <= res_c;
                copro_flags    <= flags_c;
            end
            if (abort)     copro_busy     <= 1'b0;
            if (release_c) copro_complete <= 1'b0;
        end
    end

    // One restoring quotient bit per EXEC cycle; the last cycle before completion is spare
    always_ff @(posedge clk) begin
        if (capture) begin
            a_q    <= copro_op0;
            b_q    <= copro_op1;
            op_q   <= copro_opcode[1:0];
            rem_q  <= {1'b0, hidden_mant(copro_op0)};
            quot_q <= '0;
        end else if (state_q == S_EXEC && cnt_q > CW'(1)) begin
            if (rem_q >= {1'b0, mb}) begin
                rem_q  <= (rem_q - {1'b0, mb}) << 1;
                quot_q <= {quot_q[MW-1:0], 1'b1};
            end else begin
                rem_q  <= rem_q << 1;
                quot_q <= {quot_q[MW-1:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_float_copro_mc.sv
// Scoreboard bench for float_copro_mc: expected results queued at drive time, compared at complete.
module tb_float_copro_mc;
    localparam int W = 32;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, DIV = 2'b10, MUL = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         copro_valid = 1'b0;
    logic [10:0]  copro_opcode = '0;
    logic [W-1:0] copro_op0 = '0;
    logic [W-1:0] copro_op1 = '0;
    logic         copro_complete;
    logic [W-1:0] copro_result;
    logic         copro_busy;
    logic [3:0]   copro_flags;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } exp_t;
    exp_t sb_q[$];
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    float_copro_mc #(.Nm(23), .Ne(8), .ADD_LAT(2), .MUL_LAT(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .copro_valid(copro_valid),
        .copro_opcode(copro_opcode),
        .copro_op0(copro_op0),
        .copro_op1(copro_op1),
        .copro_complete(copro_complete),
        .copro_result(copro_result),
        .copro_busy(copro_busy),
        .copro_flags(copro_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic [3:0] fl,
                          input int hold);
        exp_t e;
        int   cyc;
        bit   done;
        bit   early_ok;
        bit   stable;
        int   lat;
        lat = (op == MUL) ? 3 : (op == DIV) ? 27 : 2;
        @(negedge clk);
        copro_valid  = 1'b1;
        copro_opcode = {9'($urandom_range(0, 511)), op};
        copro_op0    = a;
        copro_op1    = b;
        sb_q.push_back('{res, fl, lat});
        @(posedge clk); #1;
        check({tag, "_busy_cap"}, 32'(copro_busy), 32'd1);
        check({tag, "_flags_clr"}, 32'(copro_flags), 32'd0);
        copro_op0 = $urandom();
        copro_op1 = $urandom();
        cyc = 0; done = 1'b0; early_ok = 1'b1;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (copro_complete) done = 1'b1;
            else if (!copro_busy) early_ok = 1'b0;
        end
        e = sb_q.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_during"}, 32'(early_ok), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        check({tag, "_result"}, copro_result, e.res);
        check({tag, "_flags"}, 32'(copro_flags), 32'(e.flags));
        check({tag, "_busy_end"}, 32'(copro_busy), 32'd0);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!copro_complete || copro_busy || copro_result !== e.res) stable = 1'b0;
            end
            check({tag, "_hold_stable"}, 32'(stable), 32'd1);
        end
        @(negedge clk);
        copro_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_complete_drop"}, 32'(copro_complete), 32'd0);
        check({tag, "_result_kept"}, copro_result, e.res);
        last_res = e.res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_complete", 32'(copro_complete), 32'd0);
        check("rst_busy", 32'(copro_busy), 32'd0);
        check("rst_result", copro_result, 32'd0);
        check("rst_flags", 32'(copro_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add",       ADD, 32'h3FC00000, 32'h40100000, 32'h40700000, 4'b0000, 0);
        run_op("sub",       SUB, 32'h3FC00000, 32'h40100000, 32'hBF400000, 4'b0000, 0);
        run_op("mul",       MUL, 32'h40400000, 32'hC0000000, 32'hC0C00000, 4'b0000, 0);
        run_op("mul_ovf",   MUL, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0010, 0);
        run_op("div",       DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 0);
        run_op("div_dbz",   DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0);
        run_op("add_nan",   ADD, 32'h7FC00000, 32'h12345678, 32'h7FC00000, 4'b1000, 0);
        run_op("div_00",    DIV, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
        run_op("hshake",    MUL, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 5);
        run_op("sub_trunc", SUB, 32'h3F800000, 32'h33000000, 32'h3F7FFFFF, 4'b0000, 0);
        run_op("sub_zero",  SUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 0);
        run_op("add_zop",   ADD, 32'h00000000, 32'hC0400000, 32'hC0400000, 4'b0000, 0);
        run_op("mul_unf",   MUL, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, 0);
        run_op("mul_szero", MUL, 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 0);
        run_op("div_exact", DIV, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);
        run_op("div_ninf",  DIV, 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 0);
        run_op("div_ovf",   DIV, 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 0);
        run_op("sub_cancel",SUB, 32'h3F800000, 32'h3F400000, 32'h3E800000, 4'b0000, 0);

        // Abort a divide by dropping valid before the tenth EXEC edge
        @(negedge clk);
        copro_valid  = 1'b1;
        copro_opcode = {9'd0, DIV};
        copro_op0    = 32'h3F800000;
        copro_op1    = 32'h40400000;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        copro_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(copro_busy), 32'd0);
        seen = copro_complete;
        repeat (30) begin
            @(posedge clk); #1;
            if (copro_complete) seen = 1'b1;
        end
        check("abort_no_complete", 32'(seen), 32'd0);
        check("abort_result", copro_result, last_res);
        check("abort_flags", 32'(copro_flags), 32'd0);

        // Reset in the middle of a multiply
        @(negedge clk);
        copro_valid  = 1'b1;
        copro_opcode = {9'd0, MUL};
        copro_op0    = 32'h40400000;
        copro_op1    = 32'hC0000000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b0;
        copro_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_complete", 32'(copro_complete), 32'd0);
        check("midrst_busy", 32'(copro_busy), 32'd0);
        check("midrst_result", copro_result, 32'd0);
        check("midrst_flags", 32'(copro_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_after_rst", MUL, 32'h40400000, 32'hC0000000, 32'hC0C00000, 4'b0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
